// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store path: size encodings,
// access-controller FSM states and default bus widths.
package mem_pkg;

  localparam int DEF_NB_DATA = 32;
  localparam int DEF_NB_ADDR = 5;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LOAD_WAIT = 2'b01,
    ST_RMW_WRITE = 2'b10
  } state_t;

  // Encoding 2'b11 is handled exactly like a word access.
  function automatic logic size_is_word(input logic [1:0] size);
    return (size != SIZE_BYTE) && (size != SIZE_HALF);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      default:   bad = (offset != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends a load lane from a full
// memory word, and merges store data into a read word for sub-word writes.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA
) (
  input  logic [1:0]         size,
  input  logic [1:0]         offset,
  input  logic               is_unsigned,
  input  logic [NB_DATA-1:0] rdata,
  input  logic [NB_DATA-1:0] wdata,
  output logic [NB_DATA-1:0] load_data,
  output logic [NB_DATA-1:0] merged_data
);

  logic [4:0]  byte_pos;
  logic [4:0]  half_pos;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_pos  = {offset, 3'b000};
  assign half_pos  = {offset[1], 4'b0000};
  assign byte_lane = rdata[byte_pos +: 8];
  assign half_lane = rdata[half_pos +: 16];

  always_comb begin
    load_data   = rdata;
    merged_data = wdata;
    case (size)
      SIZE_BYTE: begin
        load_data   = {{(NB_DATA-8){byte_lane[7] & ~is_unsigned}}, byte_lane};
        merged_data = rdata;
        merged_data[byte_pos +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        load_data   = {{(NB_DATA-16){half_lane[15] & ~is_unsigned}}, half_lane};
        merged_data = rdata;
        merged_data[half_pos +: 16] = wdata[15:0];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller in front of the word-only data memory.
// Loads take a read plus a wait cycle; sub-word stores are read-modify-write.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int NB_DATA     = DEF_NB_DATA,
  parameter int NB_ADDR     = DEF_NB_ADDR,
  parameter int NB_CPU_ADDR = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic                   i_mem_read,
  input  logic                   i_mem_write,
  input  logic [1:0]             i_size,
  input  logic                   i_unsigned,
  input  logic [NB_CPU_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0]     i_wdata,
  input  logic [NB_DATA-1:0]     i_mem_rdata,
  output logic                   o_mem_enable,
  output logic                   o_mem_read,
  output logic                   o_mem_write,
  output logic [NB_ADDR-1:0]     o_mem_addr,
  output logic [NB_DATA-1:0]     o_mem_wdata,
  output logic [NB_DATA-1:0]     o_load_data,
  output logic                   o_load_valid,
  output logic                   o_misaligned,
  output logic                   o_stall
);

  state_t state;
  state_t next_state;

  logic [NB_ADDR-1:0] lat_word;
  logic [1:0]         lat_offset;
  logic [1:0]         lat_size;
  logic               lat_unsigned;
  logic [NB_DATA-1:0] lat_wdata;

  logic               has_op;
  logic               misaligned_now;
  logic               accept;
  logic               store_word;
  logic [NB_DATA-1:0] align_load;
  logic [NB_DATA-1:0] align_merge;
  logic               unused_addr_bits;

  // Byte address bits above the word index simply wrap the memory.
  assign unused_addr_bits = ^i_addr[NB_CPU_ADDR-1:NB_ADDR+2];

  assign has_op         = i_mem_read | i_mem_write;
  assign misaligned_now = is_misaligned(i_size, i_addr[1:0]);
  assign accept         = (state == ST_IDLE) & i_valid & has_op & ~misaligned_now;
  assign store_word     = size_is_word(i_size);

  mem_lane_align #(
    .NB_DATA (NB_DATA)
  ) u_lane_align (
    .size        (lat_size),
    .offset      (lat_offset),
    .is_unsigned (lat_unsigned),
    .rdata       (i_mem_rdata),
    .wdata       (lat_wdata),
    .load_data   (align_load),
    .merged_data (align_merge)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      lat_word     <= '0;
      lat_offset   <= '0;
      lat_size     <= '0;
      lat_unsigned <= 1'b0;
      lat_wdata    <= '0;
    end else if (accept) begin
      lat_word     <= i_addr[NB_ADDR+1:2];
      lat_offset   <= i_addr[1:0];
      lat_size     <= i_size;
      lat_unsigned <= i_unsigned;
      lat_wdata    <= i_wdata;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (i_mem_write) begin
            next_state = store_word ? ST_IDLE : ST_RMW_WRITE;
          end else begin
            next_state = ST_LOAD_WAIT;
          end
        end
      end
      ST_LOAD_WAIT: next_state = ST_IDLE;
      ST_RMW_WRITE: next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Reset gates every strobe so an in-flight RMW write is dropped.
  always_comb begin
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_stall     = 1'b0;
    o_mem_addr  = lat_word;
    o_mem_wdata = '0;
    case (state)
      ST_IDLE: begin
        o_mem_addr = i_addr[NB_ADDR+1:2];
        if (accept && !i_reset) begin
          if (i_mem_write && store_word) begin
            o_mem_write = 1'b1;
            o_mem_wdata = i_wdata;
          end else begin
            o_mem_read = 1'b1;
            o_stall    = 1'b1;
          end
        end
      end
      ST_RMW_WRITE: begin
        if (!i_reset) begin
          o_mem_write = 1'b1;
          o_mem_wdata = align_merge;
        end
      end
      default: begin
      end
    endcase
  end

  assign o_mem_enable = o_mem_read | o_mem_write;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_load_data  <= '0;
      o_load_valid <= 1'b0;
      o_misaligned <= 1'b0;
    end else begin
      o_load_valid <= (state == ST_LOAD_WAIT);
      o_misaligned <= (state == ST_IDLE) & i_valid & has_op & misaligned_now;
      if (state == ST_LOAD_WAIT) begin
        o_load_data <= align_load;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural 32x32 data
// memory (registered read) attached to its strobes.
module tb_mem_access_ctrl;

  logic        i_clock;
  logic        i_reset;
  logic        i_valid;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [31:0] i_mem_rdata;
  logic        o_mem_enable;
  logic        o_mem_read;
  logic        o_mem_write;
  logic [4:0]  o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] o_load_data;
  logic        o_load_valid;
  logic        o_misaligned;
  logic        o_stall;

  logic [31:0] tb_mem [0:31];
  logic        mem_clear;
  logic [31:0] model_ld;
  int          check_count;
  int          pass_count;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic        exp_wr_issue;
    logic        exp_rmw;
    logic        exp_misal;
    logic        exp_lv;
    logic [31:0] exp_ld;
    logic [4:0]  exp_word;
    logic [31:0] exp_mem;
  } vec_t;

  localparam int NUM_VECS = 22;
  vec_t vecs [NUM_VECS];

  mem_access_ctrl dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_size       (i_size),
    .i_unsigned   (i_unsigned),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_mem_rdata  (i_mem_rdata),
    .o_mem_enable (o_mem_enable),
    .o_mem_read   (o_mem_read),
    .o_mem_write  (o_mem_write),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_load_data  (o_load_data),
    .o_load_valid (o_load_valid),
    .o_misaligned (o_misaligned),
    .o_stall      (o_stall)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  always @(posedge i_clock) begin
    if (mem_clear) begin
      for (int k = 0; k < 32; k++) tb_mem[k] <= 32'h0;
      i_mem_rdata <= 32'h0;
    end else begin
      if (o_mem_write) tb_mem[o_mem_addr] <= o_mem_wdata;
      if (o_mem_read)  i_mem_rdata <= tb_mem[o_mem_addr];
    end
  end

  task automatic checkOutput(input string what, input logic [31:0] act,
                             input logic [31:0] exp);
    check_count++;
    if (act === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %08h, expected %08h", what, act, exp);
    end
  endtask

  task automatic driveOp(input logic rd, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata);
    i_valid     = 1'b1;
    i_mem_read  = rd;
    i_mem_write = wr;
    i_size      = size;
    i_unsigned  = uns;
    i_addr      = addr;
    i_wdata     = wdata;
  endtask

  task automatic dropOp();
    i_valid     = 1'b0;
    i_mem_read  = 1'b0;
    i_mem_write = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(posedge i_clock); #1;
    driveOp(v.rd, v.wr, v.size, v.uns, v.addr, v.wdata);
    @(negedge i_clock);
    checkOutput($sformatf("v%0d issue read", idx), {31'b0, o_mem_read}, {31'b0, v.exp_stall});
    checkOutput($sformatf("v%0d issue write", idx), {31'b0, o_mem_write}, {31'b0, v.exp_wr_issue});
    checkOutput($sformatf("v%0d issue stall", idx), {31'b0, o_stall}, {31'b0, v.exp_stall});
    if (v.exp_stall || v.exp_wr_issue)
      checkOutput($sformatf("v%0d issue addr", idx), {27'b0, o_mem_addr}, {27'b0, v.exp_word});
    if (v.exp_wr_issue)
      checkOutput($sformatf("v%0d issue wdata", idx), o_mem_wdata, v.exp_mem);
    if (v.exp_stall) begin
      @(posedge i_clock); #1;
      @(negedge i_clock);
      checkOutput($sformatf("v%0d second stall", idx), {31'b0, o_stall}, 32'h0);
      checkOutput($sformatf("v%0d second read", idx), {31'b0, o_mem_read}, 32'h0);
      checkOutput($sformatf("v%0d second write", idx), {31'b0, o_mem_write}, {31'b0, v.exp_rmw});
      if (v.exp_rmw) begin
        checkOutput($sformatf("v%0d rmw addr", idx), {27'b0, o_mem_addr}, {27'b0, v.exp_word});
        checkOutput($sformatf("v%0d rmw wdata", idx), o_mem_wdata, v.exp_mem);
      end
    end
    @(posedge i_clock); #1;
    dropOp();
    if (v.exp_lv) model_ld = v.exp_ld;
    @(negedge i_clock);
    checkOutput($sformatf("v%0d load_valid", idx), {31'b0, o_load_valid}, {31'b0, v.exp_lv});
    checkOutput($sformatf("v%0d load_data", idx), o_load_data, model_ld);
    checkOutput($sformatf("v%0d misaligned", idx), {31'b0, o_misaligned}, {31'b0, v.exp_misal});
    checkOutput($sformatf("v%0d after enable", idx), {31'b0, o_mem_enable}, 32'h0);
    checkOutput($sformatf("v%0d mem word", idx), tb_mem[v.exp_word], v.exp_mem);
  endtask

  initial begin
    logic exp_st [5];
    check_count = 0;
    pass_count  = 0;
    model_ld    = 32'h0;

    //            rd    wr    size   uns   addr        wdata         stl   wri   rmw   mis   lv    ld            word  mem
    vecs[0]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h10,     32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'd4,  32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h10,     32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 5'd4,  32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h10,     32'h11223344, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'd4,  32'h11223344};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h13,     32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000011, 5'd4,  32'h11223344};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h12,     32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00001122, 5'd4,  32'h11223344};
    vecs[5]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h11,     32'h00000084, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        5'd4,  32'h11228444};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h11,     32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFF84, 5'd4,  32'h11228444};
    vecs[7]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h11,     32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000084, 5'd4,  32'h11228444};
    vecs[8]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h10,     32'h11223344, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'd4,  32'h11223344};
    vecs[9]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h11,     32'h123456AA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        5'd4,  32'h1122AA44};
    vecs[10] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h12,     32'h0000BEEF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        5'd4,  32'hBEEFAA44};
    vecs[11] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h13,     32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        5'd4,  32'hBEEFAA44};
    vecs[12] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h12,     32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        5'd4,  32'hBEEFAA44};
    vecs[13] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h90,     32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'd4,  32'hCAFEF00D};
    vecs[14] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h12,     32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000CAFE, 5'd4,  32'hCAFEF00D};
    vecs[15] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h12,     32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFCAFE, 5'd4,  32'hCAFEF00D};
    vecs[16] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h10,     32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFF00D, 5'd4,  32'hCAFEF00D};
    vecs[17] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h10,     32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000000D, 5'd4,  32'hCAFEF00D};
    vecs[18] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h7C,     32'h80000001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'd31, 32'h80000001};
    vecs[19] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h7F,     32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFF80, 5'd31, 32'h80000001};
    vecs[20] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h7C,     32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80000001, 5'd31, 32'h80000001};
    vecs[21] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h7E,     32'h00001234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        5'd31, 32'h12340001};

    // Reset with a load pending on the inputs: nothing may be issued.
    i_reset   = 1'b1;
    mem_clear = 1'b1;
    driveOp(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    checkOutput("reset stall", {31'b0, o_stall}, 32'h0);
    checkOutput("reset read", {31'b0, o_mem_read}, 32'h0);
    checkOutput("reset write", {31'b0, o_mem_write}, 32'h0);
    checkOutput("reset load_data", o_load_data, 32'h0);
    checkOutput("reset load_valid", {31'b0, o_load_valid}, 32'h0);
    checkOutput("reset misaligned", {31'b0, o_misaligned}, 32'h0);
    @(posedge i_clock); #1;
    i_reset   = 1'b0;
    mem_clear = 1'b0;
    dropOp();

    for (int i = 0; i < NUM_VECS; i++) applyStimulus(vecs[i], i);

    // Reset landing in the RMW_WRITE cycle of a byte store.
    $display("[TB] reset during read-modify-write");
    @(posedge i_clock); #1;
    driveOp(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h00000055);
    @(negedge i_clock);
    checkOutput("rst-rmw issue read", {31'b0, o_mem_read}, 32'h1);
    @(posedge i_clock); #1;
    i_reset = 1'b1;
    @(negedge i_clock);
    checkOutput("rst-rmw write strobe", {31'b0, o_mem_write}, 32'h0);
    checkOutput("rst-rmw stall", {31'b0, o_stall}, 32'h0);
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    dropOp();
    model_ld = 32'h0;
    @(negedge i_clock);
    checkOutput("rst-rmw enable", {31'b0, o_mem_enable}, 32'h0);
    checkOutput("rst-rmw stall after", {31'b0, o_stall}, 32'h0);
    checkOutput("rst-rmw load_data", o_load_data, 32'h0);
    checkOutput("rst-rmw load_valid", {31'b0, o_load_valid}, 32'h0);
    checkOutput("rst-rmw misaligned", {31'b0, o_misaligned}, 32'h0);
    checkOutput("rst-rmw mem word", tb_mem[4], 32'hCAFEF00D);

    // Back-to-back LW, SB, SW with i_valid held high throughout.
    $display("[TB] back-to-back stream");
    exp_st = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 5; c++) begin
      @(posedge i_clock); #1;
      if (c == 0) driveOp(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      if (c == 2) driveOp(1'b0, 1'b1, 2'b00, 1'b0, 32'h7C, 32'h00000077);
      if (c == 4) driveOp(1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'hA5A5A5A5);
      @(negedge i_clock);
      checkOutput($sformatf("stream c%0d stall", c), {31'b0, o_stall}, {31'b0, exp_st[c]});
      if (c == 2) begin
        checkOutput("stream c2 load_valid", {31'b0, o_load_valid}, 32'h1);
        checkOutput("stream c2 load_data", o_load_data, 32'hCAFEF00D);
      end
      if (c == 3) begin
        checkOutput("stream c3 load_valid", {31'b0, o_load_valid}, 32'h0);
        checkOutput("stream c3 rmw wdata", o_mem_wdata, 32'h12340077);
      end
      if (c == 4) begin
        checkOutput("stream c4 write", {31'b0, o_mem_write}, 32'h1);
        checkOutput("stream c4 addr", {27'b0, o_mem_addr}, 32'd5);
      end
    end
    @(posedge i_clock); #1;
    dropOp();
    @(negedge i_clock);
    checkOutput("stream word31", tb_mem[31], 32'h12340077);
    checkOutput("stream word5", tb_mem[5], 32'hA5A5A5A5);
    checkOutput("stream word4", tb_mem[4], 32'hCAFEF00D);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
